ov5640_dvp_tx: RTL and testbench
================================

# ov5640_dvp_tx

DVP (OV5640-style) video transmitter: takes a 16-bit RGB565 pixel stream over a valid/ready handshake and emits camera-format vsync/href/8-bit data with programmable frame timing. It is the transmit end of the camera capture path. It drives synthetic or SDRAM-sourced frames into the capture logic for loopback test, and it feeds downstream DVP consumers. Single clock domain; one output byte per `clk`.

## Interface
- `H_ACTIVE`, 1024, active pixels per line (each pixel = 2 bytes)
- `H_BLANK`, 256, href-low clocks after each active line
- `V_ACTIVE`, 768, active lines per frame
- `VSYNC_LEN`, 4, lines with vsync high
- `V_BACK`, 16, blank lines after vsync, before first active line
- `V_FRONT`, 4, blank lines after last active line
- `clk  in  1  system/pixel-byte clock`
- `rst_n  in  1  asynchronous active-low reset`
- `en  in  1  frame enable; sampled only at frame boundaries`
- `pix_data  in  16  RGB565 pixel`
- `pix_valid  in  1  pix_data valid`
- `pix_ready  out  1  block accepts a pixel this cycle`
- `vsync  out  1  frame sync, active high`
- `href  out  1  line valid, active high`
- `data_out  out  8  DVP byte`
- `frame_start  out  1  one-cycle pulse on first vsync-high cycle`
- `underflow  out  1  one-cycle pulse when a pixel slot found no valid pixel`

## Operation
- Line length: LINE_CLKS = 2*H_ACTIVE + H_BLANK clocks for all line types.
- States:
  - IDLE: exit to VSYNC when `en`=1.
  - VSYNC: VSYNC_LEN lines.
  - VBACK: V_BACK lines.
  - ACTIVE: V_ACTIVE lines. In each line, href=1 for slots 0..2*H_ACTIVE-1, then href=0 for H_BLANK clocks.
  - VFRONT: V_FRONT lines. At end, go to VSYNC if `en`=1, else IDLE.
- Counters: column counter 0..LINE_CLKS-1; line counter per state. Widths are `$clog2` of the maximum count.
- Byte order: high byte `pix_data[15:8]` in even slot, low byte `[7:0]` in the following odd slot.
- Handshake: `pix_ready`=1 exactly in the cycle before each even active slot, i.e. H_ACTIVE cycles per line. It depends only on counters/state, never on `pix_valid`.
- Pixel transfer occurs on a rising edge with `pix_ready & pix_valid`. The pixel is held in an internal 16-bit register.
- Slot with `pix_valid`=0 at its ready cycle:
  - pixel 0x0000 is emitted;
  - `underflow` pulses coincident with the high byte.
  - Frame timing never stalls.
- Outside href: `data_out`=0x00.
- `en` deasserted mid-frame: the current frame completes, then IDLE.
- Reset (any time, including mid-line): all outputs low immediately; counters 0; state IDLE; pixel register 0.

## Timing
- All outputs are registered except `pix_ready`, which is combinational from state/counters.
- `en` high in IDLE at edge t: vsync=1 and `frame_start`=1 from cycle t+1.
- Frame length: (VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT) * LINE_CLKS clocks. Back-to-back frames have no gap.
- Pixel latency: accepted at edge e; high byte on `data_out` cycle e+1 (href=1); low byte e+2.
- vsync and href are never simultaneously high.

## Structure
- Shared package `ov5640_pkg`:
  - state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - default 1024x768 timing constants, shared with the capture side.
- No sub-module needed. Optional `dvp_timing_cnt` (column/line counters plus state) is acceptable if reused by a future VGA-style timing generator.

## Test plan
Small parameters for all tests: H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VSYNC_LEN=1, V_BACK=1, V_FRONT=1. This gives LINE_CLKS=11 and 55 clocks/frame.

- Reset/idle: hold `en`=0 after reset. `vsync`/`href`/`data_out`/`pix_ready` stay 0 for 200 clocks.
- Single frame timing: pulse `en`, supply pixels 0x1234, 0x5678, … continuously.
  - `frame_start` one cycle.
  - vsync high 11 clocks, then 11 blank clocks.
  - Each active line: href high 8 clocks (bytes 12 34 56 78 …), then low 3 clocks.
  - Then 11 front clocks and return to IDLE.
  - 8 pixels accepted total.
- Underflow: drop `pix_valid` at the 3rd ready cycle. Bytes 00 00 appear in slots 4-5 with a one-cycle `underflow`; the line length is unchanged; the next pixel resumes in slot 6.
- Continuous frames: hold `en`=1.
  - vsync rises again exactly 55 clocks after the previous rise.
  - Deassert `en` mid-frame 2: frame 2 completes, then IDLE.
- Reset mid-line: assert `rst_n`=0 during href. All outputs go 0 asynchronously. After release with `en`=1, a fresh frame starts with `frame_start`.
- Backpressure check: `pix_valid` constant 1 with a counted source. Exactly H_ACTIVE*V_ACTIVE=8 transfers per frame, none during blanking.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared DVP definitions: frame-timing state encoding and the default
// 1024x768 timing, also used by the capture side.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } dvp_state_e;

  localparam int DEF_H_ACTIVE  = 1024;
  localparam int DEF_H_BLANK   = 256;
  localparam int DEF_V_ACTIVE  = 768;
  localparam int DEF_VSYNC_LEN = 4;
  localparam int DEF_V_BACK    = 16;
  localparam int DEF_V_FRONT   = 4;

  // Counter width for values 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/ov5640_dvp_tx.sv
// DVP transmitter: serialises RGB565 pixels into vsync/href/8-bit bytes
// with programmable frame timing; the frame never stalls on a missing pixel.
module ov5640_dvp_tx
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int VSYNC_LEN = DEF_VSYNC_LEN,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int V_FRONT   = DEF_V_FRONT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data_out,
  output logic        frame_start,
  output logic        underflow
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_AB    = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int MAX_CD    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int COL_W     = cnt_width(LINE_CLKS);
  localparam int LINE_W    = cnt_width(MAX_LINES);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_CLKS - 1);
  localparam logic [COL_W:0]   HREF_END = (COL_W + 1)'(2 * H_ACTIVE);

  dvp_state_e        state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [LINE_W-1:0] line, line_nxt, line_last;
  logic              eol, last_line;
  logic [15:0]       pix_reg, pix_reg_nxt;
  logic              vsync_d, href_d, frame_start_d, underflow_d;
  logic [7:0]        data_d;

  assign eol       = (col == COL_LAST);
  assign last_line = (line == line_last);

  always_comb begin
    line_last = '0;
    unique case (state)
      VSYNC:   line_last = LINE_W'(VSYNC_LEN - 1);
      VBACK:   line_last = LINE_W'(V_BACK - 1);
      ACTIVE:  line_last = LINE_W'(V_ACTIVE - 1);
      VFRONT:  line_last = LINE_W'(V_FRONT - 1);
      default: line_last = '0;
    endcase
  end

  // Next frame position; en only matters in IDLE and at the end of VFRONT.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    line_nxt  = line;
    if (state == IDLE) begin
      col_nxt  = '0;
      line_nxt = '0;
      if (en) state_nxt = VSYNC;
    end else begin
      col_nxt = eol ? '0 : col + 1'b1;
      if (eol) begin
        if (last_line) begin
          line_nxt = '0;
          unique case (state)
            VSYNC:   state_nxt = VBACK;
            VBACK:   state_nxt = ACTIVE;
            ACTIVE:  state_nxt = VFRONT;
            VFRONT:  state_nxt = en ? VSYNC : IDLE;
            default: state_nxt = IDLE;
          endcase
        end else begin
          line_nxt = line + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next position so the flops line up with it.
  always_comb begin
    href_d        = (state_nxt == ACTIVE) && ({1'b0, col_nxt} < HREF_END);
    pix_ready     = href_d && !col_nxt[0];
    vsync_d       = (state_nxt == VSYNC);
    frame_start_d = (state_nxt == VSYNC) && (state != VSYNC);
    underflow_d   = pix_ready && !pix_valid;
    pix_reg_nxt   = pix_reg;
    data_d        = 8'h00;
    if (pix_ready) pix_reg_nxt = pix_valid ? pix_data : 16'h0000;
    if (href_d) begin
      if (!col_nxt[0]) data_d = pix_valid ? pix_data[15:8] : 8'h00;
      else             data_d = pix_reg[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      line        <= '0;
      pix_reg     <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data_out    <= 8'h00;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      line        <= line_nxt;
      pix_reg     <= pix_reg_nxt;
      vsync       <= vsync_d;
      href        <= href_d;
      data_out    <= data_d;
      frame_start <= frame_start_d;
      underflow   <= underflow_d;
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Bench for ov5640_dvp_tx at small timing: a per-cycle frame model plus a
// byte scoreboard filled when pixels are offered and drained on href.
module tb_ov5640_dvp_tx;

  localparam int HA = 4, HB = 3, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_valid = 1'b0;
  logic        pix_ready, vsync, href, frame_start, underflow;
  logic [7:0]  data_out;

  ov5640_dvp_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vsync(vsync), .href(href), .data_out(data_out),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       uf;
  } exp_byte_t;

  typedef struct {
    string name;
    int    drop_idx;
    int    en_drop_k;
    int    exp_xfers;
    int    exp_uf;
  } vec_t;

  exp_byte_t sb[$];
  vec_t      vecs[4];
  int        tests = 0;
  int        fails = 0;
  int        pix_n = 0;

  function automatic logic [15:0] pixel(input int n);
    return 16'h1234 + 16'(n) * 16'h4444;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s (k=%0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit ready_exp, input bit drop, input bit en_val);
    exp_byte_t e;
    en        = en_val;
    pix_data  = pixel(pix_n);
    pix_valid = !(ready_exp && drop);
    if (ready_exp) begin
      if (drop) begin
        e.b = 8'h00; e.uf = 1'b1; sb.push_back(e);
        e.b = 8'h00; e.uf = 1'b0; sb.push_back(e);
      end else begin
        e.b = pix_data[15:8]; e.uf = 1'b0; sb.push_back(e);
        e.b = pix_data[7:0];  e.uf = 1'b0; sb.push_back(e);
        pix_n++;
      end
    end
  endtask

  // Runs one frame that begins on the next clock edge (en must be high).
  task automatic runFrame(input vec_t v);
    int ready_idx = 0;
    int xfers = 0;
    int ufs = 0;
    en = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      int  ln, cl, nln, ncl;
      bit  exp_vs, exp_href, exp_rdy, drop, en_val;
      exp_byte_t e;
      tick();
      ln  = k / LINE;       cl  = k % LINE;
      nln = (k + 1) / LINE; ncl = (k + 1) % LINE;
      exp_vs   = (ln < VS);
      exp_href = (ln >= VS + VB) && (ln < VS + VB + VA) && (cl < 2 * HA);
      exp_rdy  = (k + 1 < FRAME) && (nln >= VS + VB) && (nln < VS + VB + VA) &&
                 (ncl < 2 * HA) && (ncl % 2 == 0);
      checkOutput({v.name, ":vsync"}, k, 32'(vsync), 32'(exp_vs));
      checkOutput({v.name, ":href"}, k, 32'(href), 32'(exp_href));
      checkOutput({v.name, ":frame_start"}, k, 32'(frame_start), 32'(k == 0));
      checkOutput({v.name, ":pix_ready"}, k, 32'(pix_ready), 32'(exp_rdy));
      if (exp_href) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL %s:scoreboard (k=%0d): got empty queue, expected a byte", v.name, k);
        end else begin
          e = sb.pop_front();
          checkOutput({v.name, ":data_out"}, k, 32'(data_out), 32'(e.b));
          checkOutput({v.name, ":underflow"}, k, 32'(underflow), 32'(e.uf));
        end
      end else begin
        checkOutput({v.name, ":data_out_blank"}, k, 32'(data_out), 32'h0);
        checkOutput({v.name, ":underflow_blank"}, k, 32'(underflow), 32'h0);
      end
      if (underflow) ufs++;
      drop   = exp_rdy && (ready_idx == v.drop_idx);
      en_val = (v.en_drop_k < 0) || (k < v.en_drop_k);
      applyStimulus(exp_rdy, drop, en_val);
      if (pix_ready && pix_valid) xfers++;
      if (exp_rdy) ready_idx++;
    end
    checkOutput({v.name, ":transfers"}, FRAME, 32'(xfers), 32'(v.exp_xfers));
    checkOutput({v.name, ":underflows"}, FRAME, 32'(ufs), 32'(v.exp_uf));
    checkOutput({v.name, ":scoreboard_left"}, FRAME, 32'(sb.size()), 32'h0);
    if (v.en_drop_k >= 0) begin
      for (int i = 0; i < LINE; i++) begin
        tick();
        checkOutput({v.name, ":idle_vsync"}, FRAME + i, 32'(vsync), 32'h0);
        checkOutput({v.name, ":idle_fs"}, FRAME + i, 32'(frame_start), 32'h0);
        checkOutput({v.name, ":idle_ready"}, FRAME + i, 32'(pix_ready), 32'h0);
      end
    end
  endtask

  task automatic checkAllLow(input string name);
    checkOutput({name, ":vsync"}, -1, 32'(vsync), 32'h0);
    checkOutput({name, ":href"}, -1, 32'(href), 32'h0);
    checkOutput({name, ":data_out"}, -1, 32'(data_out), 32'h0);
    checkOutput({name, ":pix_ready"}, -1, 32'(pix_ready), 32'h0);
    checkOutput({name, ":frame_start"}, -1, 32'(frame_start), 32'h0);
    checkOutput({name, ":underflow"}, -1, 32'(underflow), 32'h0);
  endtask

  initial begin
    vecs[0] = '{"single", -1, 0, 8, 0};
    vecs[1] = '{"underflow", 2, 0, 7, 1};
    vecs[2] = '{"cont_f1", -1, -1, 8, 0};
    vecs[3] = '{"cont_f2", -1, 27, 8, 0};

    #3;
    checkAllLow("reset");
    #9 rst_n = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      checkOutput("idle:vsync", i, 32'(vsync), 32'h0);
      checkOutput("idle:href", i, 32'(href), 32'h0);
      checkOutput("idle:data_out", i, 32'(data_out), 32'h0);
      checkOutput("idle:pix_ready", i, 32'(pix_ready), 32'h0);
    end

    for (int i = 0; i < 4; i++) runFrame(vecs[i]);

    // Reset in the middle of the first active line, then a fresh frame.
    en = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      tick();
      en = 1'b0;
    end
    checkOutput("midline:href_before_reset", 24, 32'(href), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkAllLow("midline_reset");
    sb.delete();
    en = 1'b1;
    #2 rst_n = 1'b1;
    runFrame('{"after_reset", -1, 0, 8, 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
